// File: rtl/light_monitor.sv
// ---------------------------------------------------------------------------------------------
// light_monitor
//   Watches a three-lamp traffic signal and tracks its phase sequence
//   RED -> RED_YELLOW -> GREEN -> YELLOW -> RED. Short dark gaps inside a phase are tolerated.
//   Illegal lamp patterns, out-of-order phases and over-long phases or gaps drive the monitor
//   into an absorbing FAULT state that only reset can leave.
//
// Parameters
//   MAX_RUN      max cycles in one lit phase, dark cycles included (<= 254)
//   MAX_GAP      max consecutive dark cycles inside a phase (<= 254)
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   red_i        observed red lamp
//   yellow_i     observed yellow lamp
//   green_i      observed green lamp
//   phase_o      0 IDLE, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 YELLOW, 7 FAULT
//   blink_o      high in GREEN once a dark cycle has been seen since entry
//   cycle_cnt_o  completed YELLOW->RED transitions, wraps modulo 256
//   err_o        sticky fault flag
//   err_code_o   0 none, 1 illegal pattern, 2 illegal transition, 3 timeout
// ---------------------------------------------------------------------------------------------
module light_monitor #(
    parameter int unsigned MAX_RUN = 32,
    parameter int unsigned MAX_GAP = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       red_i,
    input  logic       yellow_i,
    input  logic       green_i,
    output logic [2:0] phase_o,
    output logic       blink_o,
    output logic [7:0] cycle_cnt_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    // State encoding equals the phase code, so phase_o is the state register itself.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RED    = 3'd1;
    localparam logic [2:0] S_RY     = 3'd2;
    localparam logic [2:0] S_GREEN  = 3'd3;
    localparam logic [2:0] S_YELLOW = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // Lamp patterns {red, yellow, green}
    localparam logic [2:0] PAT_DARK = 3'b000;
    localparam logic [2:0] PAT_R    = 3'b100;
    localparam logic [2:0] PAT_RY   = 3'b110;
    localparam logic [2:0] PAT_G    = 3'b001;
    localparam logic [2:0] PAT_Y    = 3'b010;

    localparam logic [1:0] CODE_PATTERN    = 2'd1;
    localparam logic [1:0] CODE_TRANSITION = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT    = 2'd3;

    logic [2:0] r_state;
    logic [7:0] r_run;
    logic [7:0] r_gap;
    logic       r_blink;
    logic [7:0] r_cnt;
    logic       r_err;
    logic [1:0] r_code;

    logic [2:0] w_pat;
    logic       w_illegal;
    logic       w_dark;
    logic [2:0] w_own;
    logic [2:0] w_succ;
    logic [2:0] w_succ_state;
    logic [7:0] w_run_inc;
    logic [7:0] w_gap_inc;
    logic       w_run_over;
    logic       w_gap_over;

    logic [2:0] w_state_nxt;
    logic [7:0] w_run_nxt;
    logic [7:0] w_gap_nxt;
    logic       w_blink_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_err_nxt;
    logic [1:0] w_code_nxt;

    // Pattern classification and per-state lamp table
    always_comb begin
        w_pat     = {red_i, yellow_i, green_i};
        w_dark    = (w_pat == PAT_DARK);
        w_illegal = (w_pat == 3'b101) || (w_pat == 3'b011) || (w_pat == 3'b111);

        w_own        = PAT_R;
        w_succ       = PAT_RY;
        w_succ_state = S_RY;
        case (r_state)
            S_RED: begin
                w_own        = PAT_R;
                w_succ       = PAT_RY;
                w_succ_state = S_RY;
            end
            S_RY: begin
                w_own        = PAT_RY;
                w_succ       = PAT_G;
                w_succ_state = S_GREEN;
            end
            S_GREEN: begin
                w_own        = PAT_G;
                w_succ       = PAT_Y;
                w_succ_state = S_YELLOW;
            end
            S_YELLOW: begin
                w_own        = PAT_Y;
                w_succ       = PAT_R;
                w_succ_state = S_RED;
            end
            default: begin
                w_own        = PAT_R;
                w_succ       = PAT_RY;
                w_succ_state = S_RY;
            end
        endcase
    end

    // Saturating increments and limit checks on the would-be counter values
    always_comb begin
        w_run_inc  = (r_run == 8'hFF) ? 8'hFF : r_run + 8'd1;
        w_gap_inc  = (r_gap == 8'hFF) ? 8'hFF : r_gap + 8'd1;
        w_run_over = (32'(r_run) + 32'd1) > MAX_RUN;
        w_gap_over = (32'(r_gap) + 32'd1) > MAX_GAP;
    end

    // Next-state decision. Each pattern falls into exactly one class, so testing the illegal
    // pattern first, then successor, then hold gives the required fault priority and lets a
    // successor move win over a pending timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_gap_nxt   = r_gap;
        w_blink_nxt = r_blink;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;

        if (r_state != S_FAULT) begin
            if (w_illegal) begin
                w_state_nxt = S_FAULT;
                w_err_nxt   = 1'b1;
                w_code_nxt  = CODE_PATTERN;
                w_blink_nxt = 1'b0;
            end else if (r_state == S_IDLE) begin
                if (w_pat == PAT_R) begin
                    w_state_nxt = S_RED;
                    w_run_nxt   = 8'd1;
                    w_gap_nxt   = 8'd0;
                    w_blink_nxt = 1'b0;
                end
            end else if (w_pat == w_succ) begin
                w_state_nxt = w_succ_state;
                w_run_nxt   = 8'd1;
                w_gap_nxt   = 8'd0;
                w_blink_nxt = 1'b0;
                if (r_state == S_YELLOW) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end else if (w_pat == w_own || w_dark) begin
                if (w_run_over || (w_dark && w_gap_over)) begin
                    w_state_nxt = S_FAULT;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = CODE_TIMEOUT;
                    w_blink_nxt = 1'b0;
                end else begin
                    w_run_nxt = w_run_inc;
                    w_gap_nxt = w_dark ? w_gap_inc : 8'd0;
                    if (w_dark && r_state == S_GREEN) begin
                        w_blink_nxt = 1'b1;
                    end
                end
            end else begin
                w_state_nxt = S_FAULT;
                w_err_nxt   = 1'b1;
                w_code_nxt  = CODE_TRANSITION;
                w_blink_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_run   <= 8'd0;
            r_gap   <= 8'd0;
            r_blink <= 1'b0;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_gap   <= w_gap_nxt;
            r_blink <= w_blink_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
        end
    end

    assign phase_o     = r_state;
    assign blink_o     = r_blink;
    assign cycle_cnt_o = r_cnt;
    assign err_o       = r_err;
    assign err_code_o  = r_code;

endmodule

// File: tb/tb_light_monitor.sv
// ---------------------------------------------------------------------------------------------
// tb_light_monitor
//   Self-checking bench for light_monitor with default parameters (MAX_RUN=32, MAX_GAP=4).
//   Directed scenarios check fixed expected values; a random scenario checks every cycle
//   against a phase-level reference model.
// ---------------------------------------------------------------------------------------------
module tb_light_monitor;

    localparam int MAX_RUN = 32;
    localparam int MAX_GAP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       red;
    logic       yellow;
    logic       green;
    logic [2:0] phase_o;
    logic       blink_o;
    logic [7:0] cycle_cnt_o;
    logic       err_o;
    logic [1:0] err_code_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_phase;
    int m_run;
    int m_gap;
    int m_blink;
    int m_cnt;
    int m_err;
    int m_code;

    light_monitor #(
        .MAX_RUN(MAX_RUN),
        .MAX_GAP(MAX_GAP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .red_i      (red),
        .yellow_i   (yellow),
        .green_i    (green),
        .phase_o    (phase_o),
        .blink_o    (blink_o),
        .cycle_cnt_o(cycle_cnt_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    // Lamp pattern shown during each lit phase (1..4)
    function automatic logic [2:0] lamp_of(input int ph);
        case (ph)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int next_phase(input int ph);
        return (ph % 4) + 1;
    endfunction

    function automatic bit is_illegal(input logic [2:0] p);
        return (p == 3'b101) || (p == 3'b011) || (p == 3'b111);
    endfunction

    task automatic model_fault(input int code);
        m_phase = 7;
        m_err   = 1;
        m_code  = code;
        m_blink = 0;
    endtask

    task automatic model_step(input logic [2:0] p, input logic r);
        int nr;
        int ng;
        if (r) begin
            m_phase = 0; m_run = 0; m_gap = 0; m_blink = 0;
            m_cnt = 0; m_err = 0; m_code = 0;
            return;
        end
        if (m_phase == 7) return;
        if (is_illegal(p)) begin
            model_fault(1);
        end else if (m_phase == 0) begin
            if (p == 3'b100) begin
                m_phase = 1; m_run = 1; m_gap = 0; m_blink = 0;
            end
        end else if (p == lamp_of(next_phase(m_phase))) begin
            if (m_phase == 4) m_cnt = (m_cnt + 1) % 256;
            m_phase = next_phase(m_phase);
            m_run = 1; m_gap = 0; m_blink = 0;
        end else if (p == lamp_of(m_phase) || p == 3'b000) begin
            nr = m_run + 1;
            ng = (p == 3'b000) ? m_gap + 1 : 0;
            if (nr > MAX_RUN || ng > MAX_GAP) begin
                model_fault(3);
            end else begin
                m_run = nr;
                m_gap = ng;
                if (p == 3'b000 && m_phase == 3) m_blink = 1;
            end
        end else begin
            model_fault(2);
        end
    endtask

    // Apply one pattern for one clock; returns at the following negedge for sampling
    task automatic drive(input logic [2:0] p, input logic r);
        {red, yellow, green} = p;
        rst = r;
        @(posedge clk);
        model_step(p, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(3'b111, 1'b1);
        drive(3'b100, 1'b1);
        n_checks++;
        if (phase_o !== 3'd0 || blink_o !== 1'b0 || cycle_cnt_o !== 8'd0 ||
            err_o !== 1'b0 || err_code_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got phase=%0d blink=%0b cnt=%0d err=%0b code=%0d, want all 0",
                     phase_o, blink_o, cycle_cnt_o, err_o, err_code_o);
        end
    endtask

    task automatic test_clean_cycle();
        logic [2:0] seq   [19] = '{3'b100, 3'b100, 3'b100, 3'b110, 3'b110, 3'b110,
                                   3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000,
                                   3'b001, 3'b000, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
        logic [2:0] exp_ph[19] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
                                   3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd1};
        logic       exp_bl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        drive(3'b000, 1'b1);
        for (int i = 0; i < 19; i++) begin
            drive(seq[i], 1'b0);
            n_checks++;
            if (phase_o !== exp_ph[i] || blink_o !== exp_bl[i] || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_step%0d: got phase=%0d blink=%0b err=%0b, want phase=%0d blink=%0b err=0",
                         i, phase_o, blink_o, err_o, exp_ph[i], exp_bl[i]);
            end
        end
        n_checks++;
        if (cycle_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL clean_cycle_cnt: got %0d want 1", cycle_cnt_o);
        end
    endtask

    task automatic test_illegal_transition();
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        drive(3'b010, 1'b0);
        n_checks++;
        if (phase_o !== 3'd7 || err_o !== 1'b1 || err_code_o !== 2'd2 || blink_o !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_transition: got phase=%0d err=%0b code=%0d, want 7/1/2",
                     phase_o, err_o, err_code_o);
        end
        drive(3'b010, 1'b1);
        n_checks++;
        if (phase_o !== 3'd0 || err_o !== 1'b0 || err_code_o !== 2'd0 || cycle_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_reset: got phase=%0d err=%0b code=%0d cnt=%0d, want all 0",
                     phase_o, err_o, err_code_o, cycle_cnt_o);
        end
    endtask

    task automatic test_illegal_pattern();
        logic [2:0] after[4] = '{3'b010, 3'b100, 3'b001, 3'b110};
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        drive(3'b110, 1'b0);
        drive(3'b001, 1'b0);
        drive(3'b000, 1'b0);
        drive(3'b101, 1'b0);
        n_checks++;
        if (phase_o !== 3'd7 || err_code_o !== 2'd1 || err_o !== 1'b1 || blink_o !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pattern: got phase=%0d code=%0d blink=%0b, want 7/1/0",
                     phase_o, err_code_o, blink_o);
        end
        for (int i = 0; i < 4; i++) begin
            drive(after[i], 1'b0);
            n_checks++;
            if (phase_o !== 3'd7 || err_code_o !== 2'd1 || err_o !== 1'b1 ||
                blink_o !== 1'b0 || cycle_cnt_o !== 8'd0) begin
                n_fail++;
                $display("FAIL fault_absorbing%0d: got phase=%0d code=%0d err=%0b, want 7/1/1",
                         i, phase_o, err_code_o, err_o);
            end
        end
    endtask

    task automatic test_idle();
        logic [2:0] quiet[4] = '{3'b000, 3'b110, 3'b001, 3'b010};
        drive(3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(quiet[i], 1'b0);
            n_checks++;
            if (phase_o !== 3'd0 || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold%0d: got phase=%0d err=%0b, want 0/0", i, phase_o, err_o);
            end
        end
        drive(3'b011, 1'b0);
        n_checks++;
        if (phase_o !== 3'd7 || err_code_o !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_illegal: got phase=%0d code=%0d, want 7/1", phase_o, err_code_o);
        end
    endtask

    task automatic test_gap_timeout();
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        for (int i = 0; i < MAX_GAP; i++) drive(3'b000, 1'b0);
        n_checks++;
        if (phase_o !== 3'd1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_at_limit: got phase=%0d err=%0b, want 1/0", phase_o, err_o);
        end
        drive(3'b000, 1'b0);
        n_checks++;
        if (phase_o !== 3'd7 || err_code_o !== 2'd3) begin
            n_fail++;
            $display("FAIL gap_timeout: got phase=%0d code=%0d, want 7/3", phase_o, err_code_o);
        end
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        for (int i = 0; i < MAX_GAP; i++) drive(3'b000, 1'b0);
        drive(3'b100, 1'b0);
        n_checks++;
        if (phase_o !== 3'd1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_recover: got phase=%0d err=%0b, want 1/0", phase_o, err_o);
        end
    endtask

    task automatic test_run_timeout();
        drive(3'b000, 1'b1);
        for (int i = 0; i < MAX_RUN; i++) drive(3'b100, 1'b0);
        n_checks++;
        if (phase_o !== 3'd1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL run_at_limit: got phase=%0d err=%0b, want 1/0", phase_o, err_o);
        end
        drive(3'b100, 1'b0);
        n_checks++;
        if (phase_o !== 3'd7 || err_code_o !== 2'd3) begin
            n_fail++;
            $display("FAIL run_timeout: got phase=%0d code=%0d, want 7/3", phase_o, err_code_o);
        end
        // A successor move at the limit is not a timeout
        drive(3'b000, 1'b1);
        for (int i = 0; i < MAX_RUN; i++) drive(3'b100, 1'b0);
        drive(3'b110, 1'b0);
        n_checks++;
        if (phase_o !== 3'd2 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL successor_over_timeout: got phase=%0d err=%0b, want 2/0", phase_o, err_o);
        end
    endtask

    task automatic test_wrap();
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        for (int c = 0; c < 256; c++) begin
            drive(3'b110, 1'b0);
            drive(3'b001, 1'b0);
            drive(3'b010, 1'b0);
            drive(3'b100, 1'b0);
            if (c == 254) begin
                n_checks++;
                if (cycle_cnt_o !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d want 255", cycle_cnt_o);
                end
            end
        end
        n_checks++;
        if (cycle_cnt_o !== 8'd0 || err_o !== 1'b0 || phase_o !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_zero: got cnt=%0d err=%0b phase=%0d, want 0/0/1",
                     cycle_cnt_o, err_o, phase_o);
        end
    endtask

    task automatic test_mid_reset();
        drive(3'b000, 1'b1);
        drive(3'b100, 1'b0);
        drive(3'b110, 1'b0);
        drive(3'b001, 1'b0);
        drive(3'b010, 1'b0);
        drive(3'b100, 1'b0);
        drive(3'b110, 1'b0);
        drive(3'b110, 1'b1);
        n_checks++;
        if (phase_o !== 3'd0 || cycle_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got phase=%0d cnt=%0d, want 0/0", phase_o, cycle_cnt_o);
        end
        drive(3'b110, 1'b0);
        n_checks++;
        if (phase_o !== 3'd0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ry: got phase=%0d err=%0b, want 0/0", phase_o, err_o);
        end
        drive(3'b100, 1'b0);
        n_checks++;
        if (phase_o !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_reset_r: got phase=%0d want 1", phase_o);
        end
    endtask

    task automatic test_random();
        logic [2:0] p;
        logic       r;
        int         k;
        logic [2:0] lit[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
        drive(3'b000, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 99));
            r = 1'b0;
            p = 3'b000;
            if (k < 4) begin
                p = 3'($urandom_range(0, 7));
            end else if (k < 6 || (m_phase == 7 && k < 40)) begin
                r = 1'b1;
                p = 3'($urandom_range(0, 7));
            end else if (m_phase == 0 || m_phase == 7) begin
                p = (k < 70) ? 3'b100 : lit[$urandom_range(0, 3)];
            end else if (k < 40) begin
                p = lamp_of(next_phase(m_phase));
            end else if (k < 70) begin
                p = lamp_of(m_phase);
            end else if (k < 92) begin
                p = 3'b000;
            end else begin
                p = lit[$urandom_range(0, 3)];
            end
            drive(p, r);
            n_checks++;
            if ({phase_o, blink_o, cycle_cnt_o, err_o, err_code_o} !==
                {3'(m_phase), 1'(m_blink), 8'(m_cnt), 1'(m_err), 2'(m_code)}) begin
                n_fail++;
                $display("FAIL random%0d p=%b rst=%0b: got ph=%0d bl=%0b cnt=%0d err=%0b code=%0d, want ph=%0d bl=%0d cnt=%0d err=%0d code=%0d",
                         i, p, r, phase_o, blink_o, cycle_cnt_o, err_o, err_code_o,
                         m_phase, m_blink, m_cnt, m_err, m_code);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {red, yellow, green} = 3'b000;
        m_phase = 0; m_run = 0; m_gap = 0; m_blink = 0; m_cnt = 0; m_err = 0; m_code = 0;
        @(negedge clk);
        test_reset();
        test_clean_cycle();
        test_illegal_transition();
        test_illegal_pattern();
        test_idle();
        test_gap_timeout();
        test_run_timeout();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
